// File: rtl/cfu_pkg.sv
// Shared definitions for the control flow unit: opcodes, IR field
// positions and the FSM state encoding.
package cfu_pkg;

  localparam logic [3:0] OP_BEQ              = 4'hB;
  localparam logic [3:0] OP_BNE              = 4'hC;
  localparam logic [3:0] OP_JMP              = 4'hD;
  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'hF;

  // Instruction register field positions
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int IMM6_MSB  = 5;
  localparam int IMM12_MSB = 11;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } cfu_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/cfu_decode.sv
// Combinational decode of the latched instruction. Produces the PC
// advance, taken strobes, instruction-valid pulse and halt indication;
// all outputs are zero outside the execute cycle.
module cfu_decode
  import cfu_pkg::*;
#(
  parameter logic [3:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic        exec_i,
  input  logic [15:0] ir_i,
  input  logic [15:0] rs_data_i,
  input  logic [15:0] rt_data_i,
  output logic        pc_advance_o,
  output logic        branch_taken_o,
  output logic        jump_taken_o,
  output logic        instr_valid_o,
  output logic        halt_o
);

  logic [3:0] opc;
  logic       operands_eq;

  assign opc         = opcode_of(ir_i);
  assign operands_eq = (rs_data_i == rt_data_i);

  // Halt takes priority so a HALT_OPCODE overlapping a branch opcode still stops
  always_comb begin
    pc_advance_o   = 1'b0;
    branch_taken_o = 1'b0;
    jump_taken_o   = 1'b0;
    instr_valid_o  = 1'b0;
    halt_o         = 1'b0;
    if (exec_i) begin
      if (opc == HALT_OPCODE) begin
        halt_o = 1'b1;
      end else begin
        pc_advance_o  = 1'b1;
        instr_valid_o = 1'b1;
        case (opc)
          OP_JMP:  jump_taken_o   = 1'b1;
          OP_BEQ:  branch_taken_o = operands_eq;
          OP_BNE:  branch_taken_o = ~operands_eq;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/control_flow_unit.sv
// Control flow unit: fetches the instruction at the current PC, latches it,
// resolves JMP/BEQ/BNE/HALT and drives the PC clock enable and taken strobes.
// Optional build macro CFU_STATS_EN adds saturating taken-branch and
// taken-jump counters on branch_count_po / jump_count_po.
module control_flow_unit
  import cfu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [3:0]  HALT_OPCODE    = DEFAULT_HALT_OPCODE
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic [15:0] pc_pi,
  output logic        imem_req_po,
  output logic [15:0] imem_addr_po,
  input  logic        imem_valid_pi,
  input  logic [15:0] imem_data_pi,
  output logic [2:0]  rs_addr_po,
  output logic [2:0]  rt_addr_po,
  input  logic [15:0] rs_data_pi,
  input  logic [15:0] rt_data_pi,
  output logic        pc_advance_po,
  output logic        branch_taken_po,
  output logic [5:0]  branch_immediate_po,
  output logic        jump_taken_po,
  output logic [11:0] jump_immediate_po,
  output logic [15:0] instr_po,
  output logic        instr_valid_po,
  output logic        halted_po,
`ifdef CFU_STATS_EN
  output logic [15:0] branch_count_po,
  output logic [15:0] jump_count_po,
`endif
  output logic        fault_po
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  cfu_state_e       state_q;
  logic [15:0]      ir_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             req_q;
  logic             halted_q;
  logic             fault_q;
  logic             timeout_hit;

  logic dec_advance;
  logic dec_branch;
  logic dec_jump;
  logic dec_valid;
  logic dec_halt;

  cfu_decode #(
    .HALT_OPCODE(HALT_OPCODE)
  ) u_decode (
    .exec_i        (state_q == ST_EXEC),
    .ir_i          (ir_q),
    .rs_data_i     (rs_data_pi),
    .rt_data_i     (rt_data_pi),
    .pc_advance_o  (dec_advance),
    .branch_taken_o(dec_branch),
    .jump_taken_o  (dec_jump),
    .instr_valid_o (dec_valid),
    .halt_o        (dec_halt)
  );

  assign wait_cnt_d  = wait_cnt_q + CNT_W'(1);
  assign timeout_hit = TIMEOUT_EN && (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES));

  // Fetch/execute sequencer; request, halted and fault flags are registered with the state
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q    <= ST_FETCH;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      req_q      <= 1'b1;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_valid_pi) begin
            ir_q    <= imem_data_pi;
            req_q   <= 1'b0;
            state_q <= ST_EXEC;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit) begin
              req_q   <= 1'b0;
              fault_q <= 1'b1;
              state_q <= ST_FAULT;
            end
          end
        end
        ST_EXEC: begin
          if (dec_halt) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            req_q   <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_HALTED, ST_FAULT: ;
        default: begin
          req_q   <= 1'b0;
          fault_q <= 1'b1;
          state_q <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req_po         = req_q;
  assign imem_addr_po        = req_q ? pc_pi : 16'h0000;
  assign rs_addr_po          = ir_q[RS_MSB:RS_LSB];
  assign rt_addr_po          = ir_q[RT_MSB:RT_LSB];
  assign branch_immediate_po = ir_q[IMM6_MSB:0];
  assign jump_immediate_po   = ir_q[IMM12_MSB:0];
  assign instr_po            = ir_q;
  assign pc_advance_po       = dec_advance;
  assign branch_taken_po     = dec_branch;
  assign jump_taken_po       = dec_jump;
  assign instr_valid_po      = dec_valid;
  assign halted_po           = halted_q;
  assign fault_po            = fault_q;

`ifdef CFU_STATS_EN
  logic [15:0] branch_cnt_q;
  logic [15:0] branch_cnt_d;
  logic [15:0] jump_cnt_q;
  logic [15:0] jump_cnt_d;

  // Saturating increments on taken branch / jump
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    jump_cnt_d   = jump_cnt_q;
    if (dec_branch && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (dec_jump && (jump_cnt_q != 16'hFFFF))     jump_cnt_d   = jump_cnt_q + 16'd1;
  end

  // Statistics registers, cleared by reset
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      branch_cnt_q <= '0;
      jump_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
    end
  end

  assign branch_count_po = branch_cnt_q;
  assign jump_count_po   = jump_cnt_q;
`endif

endmodule

// File: tb/tb_control_flow_unit.sv
// Directed bench for control_flow_unit: a table of instructions with
// hand-computed decode results, plus sequences for reset, HALT, fetch
// timeout and reset during a pending fetch.
module tb_control_flow_unit;

  logic        clk = 1'b0;
  logic        reset_pi;
  logic [15:0] pc_pi;
  logic        imem_req_po;
  logic [15:0] imem_addr_po;
  logic        imem_valid_pi;
  logic [15:0] imem_data_pi;
  logic [2:0]  rs_addr_po;
  logic [2:0]  rt_addr_po;
  logic [15:0] rs_data_pi;
  logic [15:0] rt_data_pi;
  logic        pc_advance_po;
  logic        branch_taken_po;
  logic [5:0]  branch_immediate_po;
  logic        jump_taken_po;
  logic [11:0] jump_immediate_po;
  logic [15:0] instr_po;
  logic        instr_valid_po;
  logic        halted_po;
  logic        fault_po;
`ifdef CFU_STATS_EN
  logic [15:0] branch_count_po;
  logic [15:0] jump_count_po;
`endif

  always #5 clk = ~clk;

  control_flow_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_pi             (clk),
    .reset_pi           (reset_pi),
    .pc_pi              (pc_pi),
    .imem_req_po        (imem_req_po),
    .imem_addr_po       (imem_addr_po),
    .imem_valid_pi      (imem_valid_pi),
    .imem_data_pi       (imem_data_pi),
    .rs_addr_po         (rs_addr_po),
    .rt_addr_po         (rt_addr_po),
    .rs_data_pi         (rs_data_pi),
    .rt_data_pi         (rt_data_pi),
    .pc_advance_po      (pc_advance_po),
    .branch_taken_po    (branch_taken_po),
    .branch_immediate_po(branch_immediate_po),
    .jump_taken_po      (jump_taken_po),
    .jump_immediate_po  (jump_immediate_po),
    .instr_po           (instr_po),
    .instr_valid_po     (instr_valid_po),
    .halted_po          (halted_po),
`ifdef CFU_STATS_EN
    .branch_count_po    (branch_count_po),
    .jump_count_po      (jump_count_po),
`endif
    .fault_po           (fault_po)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rs;
    logic [15:0] rt;
    int          lat;
    bit          noise;
    bit          e_br;
    bit          e_jmp;
    logic [2:0]  e_rsa;
    logic [2:0]  e_rta;
    logic [5:0]  e_i6;
    logic [11:0] e_i12;
  } vec_t;

  localparam int NV = 7;
  vec_t        vecs[NV];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] pc_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_pi      = 1'b1;
    imem_valid_pi = 1'b0;
    imem_data_pi  = 16'h0000;
    pc_model      = 16'h0000;
    pc_pi         = 16'h0000;
    step();
    step();
    reset_pi = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h00AA, 16'h00BB, 1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 6'h34, 12'h234};
    vecs[1] = '{16'hD7FE, 16'h0005, 16'h0005, 2, 1'b1, 1'b0, 1'b1, 3'd3, 3'd7, 6'h3E, 12'h7FE};
    vecs[2] = '{16'hB2BF, 16'h00AA, 16'h00AA, 1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 6'h3F, 12'h2BF};
    vecs[3] = '{16'hB2BF, 16'h00AA, 16'h00AB, 3, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 6'h3F, 12'h2BF};
    vecs[4] = '{16'hC2BF, 16'h0055, 16'h0055, 1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 6'h3F, 12'h2BF};
    vecs[5] = '{16'hC2BF, 16'h1234, 16'h4321, 4, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 6'h3F, 12'h2BF};
    vecs[6] = '{16'hE040, 16'h0007, 16'h0007, 1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 6'h00, 12'h040};

    rs_data_pi = 16'h0000;
    rt_data_pi = 16'h0000;
    do_reset();

    // Cycle after reset: only the fetch request and address are active
    chk("rst_req", 32'(imem_req_po), 32'd1);
    chk("rst_addr", 32'(imem_addr_po), 32'h0000);
    chk("rst_adv", 32'(pc_advance_po), 32'd0);
    chk("rst_ivalid", 32'(instr_valid_po), 32'd0);
    chk("rst_instr", 32'(instr_po), 32'h0000);
    chk("rst_halted", 32'(halted_po), 32'd0);
    chk("rst_fault", 32'(fault_po), 32'd0);
    chk("rst_jimm", 32'(jump_immediate_po), 32'h000);

    for (int i = 0; i < NV; i++) begin
      chk("fetch_req", 32'(imem_req_po), 32'd1);
      chk("fetch_addr", 32'(imem_addr_po), 32'(pc_model));
      if (vecs[i].noise) begin
        imem_valid_pi = 1'b1;
        imem_data_pi  = 16'hF000;
      end
      step();
      imem_valid_pi = 1'b0;
      for (int k = 1; k < vecs[i].lat; k++) begin
        chk("wait_req", 32'(imem_req_po), 32'd1);
        chk("wait_addr", 32'(imem_addr_po), 32'(pc_model));
        step();
      end
      imem_valid_pi = 1'b1;
      imem_data_pi  = vecs[i].instr;
      step();
      imem_valid_pi = 1'b0;
      imem_data_pi  = 16'h0000;
      rs_data_pi    = vecs[i].rs;
      rt_data_pi    = vecs[i].rt;
      #1;
      chk("exec_adv", 32'(pc_advance_po), 32'd1);
      chk("exec_ivalid", 32'(instr_valid_po), 32'd1);
      chk("exec_branch", 32'(branch_taken_po), 32'(vecs[i].e_br));
      chk("exec_jump", 32'(jump_taken_po), 32'(vecs[i].e_jmp));
      chk("exec_rsa", 32'(rs_addr_po), 32'(vecs[i].e_rsa));
      chk("exec_rta", 32'(rt_addr_po), 32'(vecs[i].e_rta));
      chk("exec_imm6", 32'(branch_immediate_po), 32'(vecs[i].e_i6));
      chk("exec_imm12", 32'(jump_immediate_po), 32'(vecs[i].e_i12));
      chk("exec_instr", 32'(instr_po), 32'(vecs[i].instr));
      chk("exec_req", 32'(imem_req_po), 32'd0);
      chk("exec_halted", 32'(halted_po), 32'd0);
      step();
      if (vecs[i].e_jmp)
        pc_model = pc_model + {{4{vecs[i].e_i12[11]}}, vecs[i].e_i12};
      else if (vecs[i].e_br)
        pc_model = pc_model + {{10{vecs[i].e_i6[5]}}, vecs[i].e_i6};
      else
        pc_model = pc_model + 16'd2;
      pc_pi = pc_model;
      #1;
      chk("post_exec_adv", 32'(pc_advance_po), 32'd0);
      if (i == 0) chk("first_next_addr", 32'(imem_addr_po), 32'h0002);
    end

    // HALT: no advance, sticky halted, no further requests
    chk("halt_fetch_req", 32'(imem_req_po), 32'd1);
    step();
    imem_valid_pi = 1'b1;
    imem_data_pi  = 16'hF000;
    step();
    imem_valid_pi = 1'b0;
    #1;
    chk("halt_exec_adv", 32'(pc_advance_po), 32'd0);
    chk("halt_exec_ivalid", 32'(instr_valid_po), 32'd0);
    chk("halt_exec_jump", 32'(jump_taken_po), 32'd0);
    step();
    for (int c = 0; c < 20; c++) begin
      imem_valid_pi = c[0];
      imem_data_pi  = 16'h1234;
      #1;
      chk("halted", 32'(halted_po), 32'd1);
      chk("halted_req", 32'(imem_req_po), 32'd0);
      chk("halted_adv", 32'(pc_advance_po), 32'd0);
      step();
    end
    do_reset();
    chk("halt_rst_halted", 32'(halted_po), 32'd0);
    chk("halt_rst_req", 32'(imem_req_po), 32'd1);
    chk("halt_rst_addr", 32'(imem_addr_po), 32'h0000);

    // Fetch timeout after four WAIT cycles without valid
    step();
    for (int c = 0; c < 4; c++) begin
      chk("to_wait_fault", 32'(fault_po), 32'd0);
      chk("to_wait_req", 32'(imem_req_po), 32'd1);
      step();
    end
    chk("to_fault", 32'(fault_po), 32'd1);
    chk("to_fault_req", 32'(imem_req_po), 32'd0);
    imem_valid_pi = 1'b1;
    imem_data_pi  = 16'hE040;
    step();
    step();
    imem_valid_pi = 1'b0;
    #1;
    chk("to_fault_sticky", 32'(fault_po), 32'd1);
    chk("to_fault_adv", 32'(pc_advance_po), 32'd0);

    // Reset in the middle of WAIT, then a fetch at the latency limit
    do_reset();
    chk("mid_rst_fault", 32'(fault_po), 32'd0);
    step();
    step();
    step();
    step();
    reset_pi = 1'b1;
    step();
    reset_pi = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req_po), 32'd1);
    chk("mid_rst_fault2", 32'(fault_po), 32'd0);
    step();
    step();
    step();
    step();
    chk("mid_rst_nofault", 32'(fault_po), 32'd0);
    imem_valid_pi = 1'b1;
    imem_data_pi  = 16'hD001;
    step();
    imem_valid_pi = 1'b0;
    #1;
    chk("mid_rst_exec_jump", 32'(jump_taken_po), 32'd1);
    chk("mid_rst_exec_adv", 32'(pc_advance_po), 32'd1);
    chk("mid_rst_exec_branch", 32'(branch_taken_po), 32'd0);
    chk("mid_rst_exec_fault", 32'(fault_po), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/control_flow_unit.md
Name: control_flow_unit

Overview:
- Drives the program counter.
- Sequences instruction fetch from instruction memory at the current PC and latches the returned 16-bit instruction.
- Resolves JMP/BEQ/BNE/HALT and produces the PC's clock-enable, branch/jump taken strobes and raw immediates.
- Sits between the program counter, the instruction memory and the register file read ports; forwards each fetched instruction downstream.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles waiting in WAIT for imem_valid_pi before FAULT; 0 disables the timeout.
- HALT_OPCODE, 4'hF: opcode that stops fetch.

Ports:
- clk_pi  in  1  clock
- reset_pi  in  1  synchronous, active-high reset
- pc_pi  in  16  current PC (program counter pc_po)
- imem_req_po  out  1  fetch request, held until valid
- imem_addr_po  out  16  fetch address (= pc_pi while requesting)
- imem_valid_pi  in  1  instruction data valid
- imem_data_pi  in  16  instruction word
- rs_addr_po  out  3  regfile read address A (= IR[11:9])
- rt_addr_po  out  3  regfile read address B (= IR[8:6])
- rs_data_pi  in  16  combinational read data A
- rt_data_pi  in  16  combinational read data B
- pc_advance_po  out  1  PC clock enable, one-cycle pulse per instruction
- branch_taken_po  out  1  branch taken, qualified by pc_advance_po
- branch_immediate_po  out  6  IR[5:0], unextended byte offset
- jump_taken_po  out  1  jump taken, qualified by pc_advance_po
- jump_immediate_po  out  12  IR[11:0], unextended byte offset
- instr_po  out  16  latched instruction (IR)
- instr_valid_po  out  1  one-cycle pulse in EXEC for non-HALT instructions
- halted_po  out  1  sticky, HALT executed
- fault_po  out  1  sticky, fetch timeout

Behaviour:
- Opcode is IR[15:12]:
  - OP_BEQ=4'hB, OP_BNE=4'hC, OP_JMP=4'hD, HALT=HALT_OPCODE.
  - All other opcodes are sequential (PC+2).
- FSM states: FETCH, WAIT, EXEC, HALTED, FAULT.
- Reset: state=FETCH, IR=0, timeout counter=0.
  - All outputs 0 in the cycle after reset, except imem_req_po=1 and imem_addr_po=pc_pi.
  - Reset overrides every state, including HALTED, FAULT and mid-WAIT. The instruction memory shares reset and drops in-flight reads.
- FETCH: assert imem_req_po, imem_addr_po=pc_pi; go to WAIT next cycle.
- WAIT:
  - Hold imem_req_po=1 and the address.
  - imem_valid_pi=1: IR<=imem_data_pi, go to EXEC.
  - Otherwise increment the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, go to FAULT.
  - Valid is never accepted in the FETCH cycle; minimum memory latency is 1.
- EXEC (exactly one cycle), decode from IR:
  - JMP: pc_advance_po=1, jump_taken_po=1.
  - BEQ: branch_taken_po=(rs_data_pi==rt_data_pi); BNE: inverse; pc_advance_po=1.
  - Other non-HALT: pc_advance_po=1, both taken strobes 0.
  - Non-HALT instructions pulse instr_valid_po and return to FETCH.
  - HALT: pc_advance_po=0, instr_valid_po=0, next state HALTED.
- branch_taken_po and jump_taken_po are never both 1, and are 0 whenever pc_advance_po=0.
- Immediates are driven continuously from IR. They are passed raw; the PC sign-extends them. Odd offsets are not checked.
- PC updates on the EXEC edge, so FETCH sees the new PC. Throughput is one instruction per (2 + memory latency) cycles.
- HALTED: halted_po=1, no requests, no advance; exit only by reset.
- FAULT: fault_po=1, no requests; exit only by reset.
- imem_valid_pi outside WAIT is ignored.

Optional Feature:
- Macro CFU_STATS_EN.
- Defined: adds outputs branch_count_po[15:0] and jump_count_po[15:0].
  - Each increments on every taken branch / jump in EXEC and saturates at 16'hFFFF.
  - Both are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cfu_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_JMP and default HALT_OPCODE;
  - field-slice constants (opcode, rs, rt, imm6, imm12 bit ranges);
  - FSM state typedef (3-bit encoding).
- One sub-module, cfu_decode: combinational IR + rs/rt data -> taken/advance/valid/halt decisions.
- FSM, IR and counters stay in the top module.

Test Plan:
- Reset, then memory latency 1 returns 16'h1234 at PC 0 -> pc_advance_po pulses in cycle 3, both taken strobes 0, instr_valid_po=1, next imem_addr_po=16'h0002.
- IR=16'hD7FE (JMP, imm 12'h7FE) -> jump_taken_po=1, jump_immediate_po=12'h7FE, branch_taken_po=0 in the same cycle.
- BEQ 16'hB2BF with rs=rt=16'h00AA -> branch_taken_po=1, branch_immediate_po=6'h3F. Repeat with rt=16'h00AB -> branch_taken_po=0, pc_advance_po=1.
- BNE with equal operands -> branch_taken_po=0; unequal -> 1.
- HALT 16'hF000 -> no pc_advance_po, halted_po=1 for ≥20 cycles, imem_req_po=0. Then reset -> halted_po=0 and fetch restarts at PC 0.
- TIMEOUT_CYCLES=4 with imem_valid_pi held 0 -> fault_po=1 after 4 WAIT cycles. A reset asserted mid-WAIT (second scenario run) -> returns to FETCH, no fault.
